// File: rtl/timer_multi_ch_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the multi-channel programmable timebase:
//   - default widths for the channel counter, channel index and prescaler
//   - channel state encoding (IDLE / RUN / DONE)
//   - clog2 helper clamped to a minimum of 1 (for channel index widths)
// -----------------------------------------------------------------------------
package timer_pkg;

    // Default channel counter width in base ticks
    localparam int CNT_W_DEF = 16;
    // Default channel index width (clog2 of the default 4 channels)
    localparam int CH_W_DEF  = 2;
    // Default prescaler counter width (2^13 >= 5000)
    localparam int PRE_W_DEF = 13;

    // Channel state encoding; DONE is only reachable in one-shot mode
    typedef enum logic [1:0] {
        CH_IDLE = 2'b00,
        CH_RUN  = 2'b01,
        CH_DONE = 2'b10
    } ch_state_e;

    // Ceiling log2, never less than 1 so that a single channel still gets a
    // one-bit index port
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((32'sd1 <<< w) < n) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/timer_multi_ch_channel.sv
// -----------------------------------------------------------------------------
// timer_channel
// One timebase channel. Counts base ticks up to a programmable period and
// produces a one-cycle terminal pulse, a square wave that toggles on every
// terminal event, and a sticky done flag in one-shot mode.
//
// Ports:
//   clk_i     in   system clock, rising edge
//   rst_i     in   asynchronous active-high reset
//   base_tick in   shared prescaler tick, one cycle wide
//   en        in   channel run enable, level sensitive
//   wr        in   config write for this channel (already decoded)
//   period    in   new period in base ticks, captured on wr
//   oneshot   in   new mode, captured on wr (1 = one-shot)
//   tick      out  terminal pulse, one cycle wide, registered
//   sq        out  square wave, registered
//   done      out  one-shot expired flag, registered
// -----------------------------------------------------------------------------
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W          = CNT_W_DEF,
    parameter int DEFAULT_PERIOD = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             base_tick,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] period,
    input  logic             oneshot,
    output logic             tick,
    output logic             sq,
    output logic             done
);

    ch_state_e        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] period_r;
    logic             oneshot_r;
    logic             tick_r;
    logic             sq_r;
    logic             done_r;
    logic [CNT_W-1:0] period_last_s;
    logic             period_zero_s;
    logic             new_period_zero_s;

    // Terminal count is period-1; only used when period_r is nonzero
    assign period_last_s     = period_r - CNT_W'(1);
    assign period_zero_s     = (period_r == '0);
    assign new_period_zero_s = (period == '0);

    // Channel state machine, counter, mode registers and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= CH_IDLE;
            cnt_r     <= '0;
            period_r  <= CNT_W'(DEFAULT_PERIOD);
            oneshot_r <= 1'b0;
            tick_r    <= 1'b0;
            sq_r      <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            tick_r <= 1'b0;
            if (wr) begin
                // A write wins over any terminal event in the same cycle:
                // no tick, no toggle, no done; the count restarts from zero.
                period_r  <= period;
                oneshot_r <= oneshot;
                cnt_r     <= '0;
                done_r    <= 1'b0;
                if (en && !new_period_zero_s) begin
                    state_r <= CH_RUN;
                end else begin
                    state_r <= CH_IDLE;
                end
            end else begin
                case (state_r)
                    CH_IDLE: begin
                        cnt_r  <= '0;
                        done_r <= 1'b0;
                        if (en && !period_zero_s) begin
                            state_r <= CH_RUN;
                        end else begin
                            state_r <= CH_IDLE;
                        end
                    end
                    CH_RUN: begin
                        // Dropping enable suppresses a coincident terminal event
                        if (!en || period_zero_s) begin
                            state_r <= CH_IDLE;
                            cnt_r   <= '0;
                        end else if (base_tick) begin
                            if (cnt_r == period_last_s) begin
                                cnt_r  <= '0;
                                tick_r <= 1'b1;
                                sq_r   <= ~sq_r;
                                if (oneshot_r) begin
                                    state_r <= CH_DONE;
                                    done_r  <= 1'b1;
                                end else begin
                                    state_r <= CH_RUN;
                                end
                            end else begin
                                cnt_r <= cnt_r + CNT_W'(1);
                            end
                        end else begin
                            cnt_r <= cnt_r;
                        end
                    end
                    CH_DONE: begin
                        // Frozen until enable drops; a write is handled above
                        if (!en) begin
                            state_r <= CH_IDLE;
                            cnt_r   <= '0;
                            done_r  <= 1'b0;
                        end else begin
                            done_r  <= 1'b1;
                        end
                    end
                    default: begin
                        state_r <= CH_IDLE;
                        cnt_r   <= '0;
                        done_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tick = tick_r;
    assign sq   = sq_r;
    assign done = done_r;

endmodule

// File: rtl/timer_multi_ch.sv
// -----------------------------------------------------------------------------
// timer_multi_ch
// Multi-channel programmable timebase. A free-running prescaler produces a
// one-cycle base tick every PRESCALE clocks; N_CH independent channels count
// base ticks to individually programmed periods.
//
// Ports:
//   clk_i          in   system clock, rising edge
//   rst_i          in   asynchronous active-high reset
//   en_i           in   per-channel run enable (N_CH)
//   cfg_we_i       in   config write strobe, single cycle
//   cfg_ch_i       in   channel index for the write (CH_W)
//   cfg_period_i   in   new period in base ticks (CNT_W)
//   cfg_oneshot_i  in   1 = one-shot, 0 = periodic
//   base_tick_o    out  prescaler tick, one cycle wide
//   tick_o         out  per-channel terminal pulse (N_CH)
//   sq_o           out  per-channel square wave (N_CH)
//   done_o         out  per-channel one-shot expired flag (N_CH)
// -----------------------------------------------------------------------------
module timer_multi_ch
    import timer_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int CNT_W          = CNT_W_DEF,
    parameter int PRESCALE       = 5000,
    parameter int PRE_W          = PRE_W_DEF,
    parameter int DEFAULT_PERIOD = 1,
    parameter int CH_W           = CH_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_CH-1:0]  en_i,
    input  logic             cfg_we_i,
    input  logic [CH_W-1:0]  cfg_ch_i,
    input  logic [CNT_W-1:0] cfg_period_i,
    input  logic             cfg_oneshot_i,
    output logic             base_tick_o,
    output logic [N_CH-1:0]  tick_o,
    output logic [N_CH-1:0]  sq_o,
    output logic [N_CH-1:0]  done_o
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    // Channel count held one bit wider than the index so N_CH itself fits
    localparam logic [CH_W:0]    N_CH_L   = (CH_W + 1)'(N_CH);

    logic [PRE_W-1:0] pre_cnt_r;
    logic             base_tick_r;
    logic             ch_in_range_s;
    logic [N_CH-1:0]  wr_s;

    // Free-running prescaler; base tick is registered so it appears the
    // cycle after the counter reaches its last value
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_cnt_r   <= '0;
            base_tick_r <= 1'b0;
        end else begin
            base_tick_r <= (pre_cnt_r == PRE_LAST);
            if (pre_cnt_r == PRE_LAST) begin
                pre_cnt_r <= '0;
            end else begin
                pre_cnt_r <= pre_cnt_r + PRE_W'(1);
            end
        end
    end

    // Writes addressed beyond the last channel are dropped
    assign ch_in_range_s = ({1'b0, cfg_ch_i} < N_CH_L);

    // One-hot write decode from the shared config bus
    always_comb begin
        wr_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr_s[i] = cfg_we_i && ch_in_range_s &&
                      ({1'b0, cfg_ch_i} == (CH_W + 1)'(i));
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        timer_channel #(
            .CNT_W          (CNT_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .base_tick (base_tick_r),
            .en        (en_i[g]),
            .wr        (wr_s[g]),
            .period    (cfg_period_i),
            .oneshot   (cfg_oneshot_i),
            .tick      (tick_o[g]),
            .sq        (sq_o[g]),
            .done      (done_o[g])
        );
    end

    assign base_tick_o = base_tick_r;

endmodule

// File: tb/tb_timer_multi_ch.sv
// -----------------------------------------------------------------------------
// tb_timer_multi_ch
// Directed bench for timer_multi_ch with PRESCALE=4, N_CH=4, CNT_W=8, plus a
// second N_CH=3 instance for the out-of-range write case. Cycle numbers in
// comments count rising edges after reset release.
// -----------------------------------------------------------------------------
module tb_timer_multi_ch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [3:0] en          = 4'b0000;
    logic       cfg_we      = 1'b0;
    logic [1:0] cfg_ch      = 2'd0;
    logic [7:0] cfg_period  = 8'd0;
    logic       cfg_oneshot = 1'b0;
    logic       base_tick;
    logic [3:0] tick;
    logic [3:0] sq;
    logic [3:0] done;

    logic [2:0] en3          = 3'b000;
    logic       cfg3_we      = 1'b0;
    logic [1:0] cfg3_ch      = 2'd0;
    logic [7:0] cfg3_period  = 8'd0;
    logic       cfg3_oneshot = 1'b0;
    logic       base_tick3;
    logic [2:0] tick3;
    logic [2:0] sq3;
    logic [2:0] done3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    timer_multi_ch #(
        .N_CH(4), .CNT_W(8), .PRESCALE(4), .PRE_W(3), .DEFAULT_PERIOD(1), .CH_W(2)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch),
        .cfg_period_i(cfg_period), .cfg_oneshot_i(cfg_oneshot),
        .base_tick_o(base_tick), .tick_o(tick), .sq_o(sq), .done_o(done)
    );

    timer_multi_ch #(
        .N_CH(3), .CNT_W(8), .PRESCALE(4), .PRE_W(3), .DEFAULT_PERIOD(1), .CH_W(2)
    ) dut3 (
        .clk_i(clk), .rst_i(rst), .en_i(en3), .cfg_we_i(cfg3_we), .cfg_ch_i(cfg3_ch),
        .cfg_period_i(cfg3_period), .cfg_oneshot_i(cfg3_oneshot),
        .base_tick_o(base_tick3), .tick_o(tick3), .sq_o(sq3), .done_o(done3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance until the selected channel ticks; n = edges waited (budget-bounded)
    task automatic wait_tick(input int sel, input int ch, input int budget, output int n);
        logic hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            cyc(1);
            n++;
            hit = (sel == 0) ? tick[ch] : tick3[ch];
        end
    endtask

    task automatic write(input logic [1:0] ch, input logic [7:0] p, input logic os);
        cfg_we      = 1'b1;
        cfg_ch      = ch;
        cfg_period  = p;
        cfg_oneshot = os;
        cyc(1);
        cfg_we      = 1'b0;
    endtask

    initial begin
        int   n;
        int   cnt_t;
        logic prev;

        // ---- reset state ----
        cyc(3);
        chk("reset_outputs", {19'd0, base_tick, tick, sq, done}, 32'd0);
        chk("reset_outputs3", {22'd0, base_tick3, tick3, sq3, done3}, 32'd0);

        // ---- test 1: default period 1 on ch0 ----
        en  = 4'b0001;
        en3 = 3'b001;
        rst = 1'b0;
        cyc(3);                                         // edge 3
        chk("t1_no_base_early", {31'd0, base_tick}, 32'd0);
        cyc(1);                                         // edge 4
        chk("t1_base_first", {31'd0, base_tick}, 32'd1);
        chk("t1_tick_not_yet", {28'd0, tick}, 32'd0);
        cyc(1);                                         // edge 5
        chk("t1_tick0", {28'd0, tick}, 32'h1);
        chk("t1_sq0_high", {28'd0, sq}, 32'h1);
        chk("t1_base_low", {31'd0, base_tick}, 32'd0);
        cyc(3);                                         // edge 8
        chk("t1_base_second", {31'd0, base_tick}, 32'd1);
        cyc(1);                                         // edge 9
        chk("t1_tick0_again", {28'd0, tick}, 32'h1);
        chk("t1_sq0_low", {28'd0, sq}, 32'h0);

        // ---- test 2: ch2 period 3 periodic ----
        en = 4'b0101;
        write(2'd2, 8'd3, 1'b0);                        // edge 10
        wait_tick(0, 2, 100, n);                        // edge 21
        chk("t2_first_latency", n, 32'd11);
        chk("t2_sq2_first", {31'd0, sq[2]}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            prev = sq[2];
            wait_tick(0, 2, 100, n);                    // edge 33 .. 141
            chk("t2_interval", n, 32'd12);
            chk("t2_sq2_toggle", {31'd0, sq[2]}, {31'd0, ~prev});
        end

        // ---- test 3: ch1 period 5 one-shot ----
        en = 4'b0111;
        write(2'd1, 8'd5, 1'b1);                        // edge 142
        wait_tick(0, 1, 100, n);                        // edge 161
        chk("t3_oneshot_latency", n, 32'd19);
        chk("t3_done_set", {31'd0, done[1]}, 32'd1);
        cnt_t = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (tick[1]) cnt_t++;
        end                                             // edge 261
        chk("t3_no_more_ticks", cnt_t, 32'd0);
        chk("t3_done_held", {31'd0, done[1]}, 32'd1);
        write(2'd1, 8'd5, 1'b1);                        // edge 262
        chk("t3_done_cleared_by_write", {31'd0, done[1]}, 32'd0);
        wait_tick(0, 1, 100, n);                        // edge 281
        chk("t3_rewrite_latency", n, 32'd19);
        chk("t3_done_again", {31'd0, done[1]}, 32'd1);
        en = 4'b0101;
        cyc(1);                                         // edge 282
        chk("t3_done_cleared_by_en", {31'd0, done[1]}, 32'd0);

        // ---- test 4: write collides with ch3 terminal event ----
        en = 4'b1101;
        write(2'd3, 8'd2, 1'b0);                        // edge 283
        wait_tick(0, 3, 100, n);                        // edge 289
        chk("t4_first_latency", n, 32'd6);
        prev = sq[3];
        cyc(7);                                         // edge 296
        write(2'd3, 8'd2, 1'b0);                        // edge 297, terminal due here
        chk("t4_collision_no_tick", {31'd0, tick[3]}, 32'd0);
        chk("t4_collision_no_toggle", {31'd0, sq[3]}, {31'd0, prev});
        wait_tick(0, 3, 100, n);                        // edge 305
        chk("t4_full_new_period", n, 32'd8);
        wait_tick(0, 2, 100, n);                        // edge 309
        chk("t4_ch2_undisturbed", n, 32'd4);

        // out-of-range write on the 3-channel variant is ignored
        cfg3_we     = 1'b1;
        cfg3_ch     = 2'd3;
        cfg3_period = 8'd0;
        cyc(1);                                         // edge 310
        cfg3_we     = 1'b0;
        wait_tick(1, 0, 100, n);                        // edge 313
        chk("t4_oob_write_ignored", n, 32'd3);
        chk("t4_oob_done3", {29'd0, done3}, 32'd0);

        // ---- test 5: period 0 and period 255 ----
        write(2'd3, 8'd0, 1'b0);                        // edge 314
        cnt_t = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (tick[3]) cnt_t++;
        end                                             // edge 354
        chk("t5_period0_no_ticks", cnt_t, 32'd0);
        chk("t5_period0_done", {31'd0, done[3]}, 32'd0);
        write(2'd3, 8'd255, 1'b0);                      // edge 355
        wait_tick(0, 3, 2000, n);                       // edge 1373
        chk("t5_p255_first", n, 32'd1018);
        wait_tick(0, 3, 2000, n);                       // edge 2393
        chk("t5_p255_interval", n, 32'd1020);

        // ---- test 6: asynchronous reset mid-cycle ----
        #3;
        rst = 1'b1;
        #1;
        chk("t6_async_clear", {19'd0, base_tick, tick, sq, done}, 32'd0);
        chk("t6_async_clear3", {22'd0, base_tick3, tick3, sq3, done3}, 32'd0);
        cyc(1);
        chk("t6_held_in_reset", {19'd0, base_tick, tick, sq, done}, 32'd0);
        en  = 4'b0001;
        rst = 1'b0;
        cyc(4);
        chk("t6_base_after_release", {31'd0, base_tick}, 32'd1);
        chk("t6_no_tick_yet", {28'd0, tick}, 32'd0);
        cyc(1);
        chk("t6_default_period_tick", {28'd0, tick}, 32'h1);
        chk("t6_sq_restart", {28'd0, sq}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
